// File: rtl/falu_seq_if.sv
// falu_seq_if: operand-issue and result-writeback handshakes of the FP ALU.
interface falu_seq_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  localparam int N = 1 + EW + MW;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/falu_seq.sv
// falu_seq: multi-cycle floating-point add/sub/mul/div, round-to-nearest-even,
// subnormals flushed to zero, one operation in flight.
module falu_seq #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic      clk,
  input  logic      rst_n,
  falu_seq_if.slave bus
);
  localparam int N    = 1 + EW + MW;
  localparam int W    = MW + 5;            // carry, hidden, MW fraction, guard, round, sticky
  localparam int CW   = $clog2(MW + 3);
  localparam int BIAS = (1 << (EW - 1)) - 1;

  typedef logic signed [EW+1:0] exp_t;
  typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  localparam exp_t         EBIAS = exp_t'(BIAS);
  localparam exp_t         EMAX  = exp_t'((1 << EW) - 1);
  localparam logic [N-1:0] QNAN  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  state_t        state_q, state_d;
  op_t           op_q;
  logic [N-1:0]  a_q, b_q, res_q;
  logic [3:0]    flags_q;
  logic          spec_q;
  logic [W-1:0]  m_q;
  exp_t          e_q;
  logic          s_q;
  logic [MW+1:0] r_q;
  logic [MW+1:0] q_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready, out_valid;

  // Field split and classification of the captured operands
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic [MW:0]   ma, mb;
  logic          sa, sb, sx;
  logic          a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;

  assign ea     = a_q[N-2:MW];
  assign eb     = b_q[N-2:MW];
  assign fa     = a_q[MW-1:0];
  assign fb     = b_q[MW-1:0];
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign sa     = a_q[N-1];
  assign sb     = b_q[N-1] ^ (op_q == OP_SUB);
  assign sx     = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign a_snan = a_nan && !fa[MW-1];
  assign b_snan = b_nan && !fb[MW-1];

  // Special-value resolution
  logic         spec_hit;
  logic [N-1:0] spec_res;
  logic [3:0]   spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res      = QNAN;
      spec_flags[3] = a_snan || b_snan;
    end else begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          if (a_inf && b_inf && (sa != sb)) begin
            spec_res = QNAN; spec_flags[3] = 1'b1;
          end
          else if (a_inf)            spec_res = {sa, {EW{1'b1}}, {MW{1'b0}}};
          else if (b_inf)            spec_res = {sb, {EW{1'b1}}, {MW{1'b0}}};
          else if (a_zero && b_zero) spec_res = {sa & sb, {(N-1){1'b0}}};
          else if (a_zero)           spec_res = {sb, eb, fb};
          else if (b_zero)           spec_res = {sa, ea, fa};
          else                       spec_hit = 1'b0;
        end
        OP_MUL: begin
          if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_res = QNAN; spec_flags[3] = 1'b1;
          end
          else if (a_inf || b_inf)   spec_res = {sx, {EW{1'b1}}, {MW{1'b0}}};
          else if (a_zero || b_zero) spec_res = {sx, {(N-1){1'b0}}};
          else                       spec_hit = 1'b0;
        end
        OP_DIV: begin
          if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN; spec_flags[3] = 1'b1;
          end
          else if (a_inf)  spec_res = {sx, {EW{1'b1}}, {MW{1'b0}}};
          else if (b_inf)  spec_res = {sx, {(N-1){1'b0}}};
          else if (b_zero) begin
            spec_res = {sx, {EW{1'b1}}, {MW{1'b0}}}; spec_flags[2] = 1'b1;
          end
          else if (a_zero) spec_res = {sx, {(N-1){1'b0}}};
          else             spec_hit = 1'b0;
        end
      endcase
    end
  end

  // Add/sub alignment with guard/round/sticky, multiplier, and one divider step
  logic              a_big;
  logic [EW-1:0]     e_big, e_sml;
  logic [EW:0]       diff, shamt;
  logic [MW+3:0]     x_big, x_sml, x_aln;
  logic [2*MW+7:0]   sh;
  logic [W-1:0]      sum;
  logic [2*MW+1:0]   prod;
  logic              r_ge;
  logic [MW+1:0]     r_sub, r_nxt;
  logic [MW+2:0]     q_nxt;

  always_comb begin
    a_big = {ea, fa} >= {eb, fb};
    e_big = a_big ? ea : eb;
    e_sml = a_big ? eb : ea;
    x_big = {(a_big ? ma : mb), 3'b000};
    x_sml = {(a_big ? mb : ma), 3'b000};
    diff  = {1'b0, e_big} - {1'b0, e_sml};
    shamt = (diff > (EW+1)'(MW + 4)) ? (EW+1)'(MW + 4) : diff;
    sh    = {x_sml, {(MW+4){1'b0}}} >> shamt;
    x_aln = sh[2*MW+7:MW+4] | {{(MW+3){1'b0}}, |sh[MW+3:0]};
    sum   = (sa == sb) ? ({1'b0, x_big} + {1'b0, x_aln}) : ({1'b0, x_big} - {1'b0, x_aln});
    prod  = {{(MW+1){1'b0}}, ma} * {{(MW+1){1'b0}}, mb};
    r_ge  = r_q >= {1'b0, mb};
    r_sub = r_ge ? (r_q - {1'b0, mb}) : r_q;
    r_nxt = r_sub << 1;
    q_nxt = {q_q, r_ge};
  end

  // Normalise, round to nearest even, pack, overflow/underflow
  logic [W-1:0]  nm;
  exp_t          ne, re;
  logic          rnd;
  logic [MW+1:0] sig;
  logic [MW-1:0] rf;
  logic [N-1:0]  pres;
  logic [3:0]    pflags;

  always_comb begin
    nm = m_q;
    ne = e_q;
    if (m_q[W-1]) begin
      nm = {1'b0, m_q[W-1:2], m_q[1] | m_q[0]};
      ne = e_q + exp_t'(1);
    end else begin
      for (int unsigned i = 0; i < W - 2; i++) begin
        if (!nm[W-2] && (nm != '0)) begin
          nm = nm << 1;
          ne = ne - exp_t'(1);
        end
      end
    end
    rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
    sig = {1'b0, 1'b1, nm[W-3:3]} + {{(MW+1){1'b0}}, rnd};
    re  = ne;
    rf  = sig[MW-1:0];
    if (sig[MW+1]) begin
      re = ne + exp_t'(1);
      rf = sig[MW:1];
    end
    pres   = '0;
    pflags = '0;
    if (m_q == '0) begin
      pres = '0;
    end else if (re >= EMAX) begin
      pres = {s_q, {EW{1'b1}}, {MW{1'b0}}}; pflags = 4'b0010;
    end else if (re <= exp_t'(0)) begin
      pres = {s_q, {(N-1){1'b0}}}; pflags = 4'b0001;
    end else begin
      pres = {s_q, re[EW-1:0], rf};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = UNPACK;
      end
      UNPACK: state_d = EXEC;
      // A special-case result already sits in res_q; skipping NORM gives the two-edge shortcut
      EXEC: begin
        if (spec_q)                                      state_d = DONE;
        else if ((op_q != OP_DIV) || (cnt_q == CW'(MW + 2))) state_d = NORM;
      end
      NORM: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, datapath registers and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; op_q <= OP_ADD;
      res_q <= '0; flags_q <= '0; spec_q <= 1'b0;
      m_q <= '0; e_q <= '0; s_q <= 1'b0;
      r_q <= '0; q_q <= '0; cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.in_a;
          b_q     <= bus.in_b;
          op_q    <= op_t'(bus.in_op);
          flags_q <= '0;
        end
        UNPACK: begin
          spec_q <= spec_hit;
          if (spec_hit) begin
            res_q   <= spec_res;
            flags_q <= spec_flags;
          end
          r_q   <= {1'b0, ma};
          q_q   <= '0;
          cnt_q <= '0;
        end
        EXEC: case (op_q)
          OP_ADD, OP_SUB: begin
            m_q <= sum;
            e_q <= exp_t'(e_big);
            s_q <= a_big ? sa : sb;
          end
          OP_MUL: begin
            m_q <= {prod[2*MW+1:MW-2], |prod[MW-3:0]};
            e_q <= exp_t'(ea) + exp_t'(eb) - EBIAS;
            s_q <= sx;
          end
          OP_DIV: begin
            r_q   <= r_nxt;
            q_q   <= q_nxt[MW+1:0];
            cnt_q <= cnt_q + CW'(1);
            m_q   <= {1'b0, q_nxt, |r_sub};
            e_q   <= exp_t'(ea) - exp_t'(eb) + EBIAS;
            s_q   <= sx;
          end
        endcase
        NORM: begin
          res_q   <= pres;
          flags_q <= pflags;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = res_q;
  assign bus.out_flags  = flags_q;

endmodule

// File: tb/tb_falu_seq.sv
// tb_falu_seq: directed vectors with a scoreboard queue; a negedge monitor
// checks result, flags, latency and hold behaviour whenever out_valid is up.
module tb_falu_seq;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    int          acc;
    string       nm;
  } exp_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  int   rel_cyc = 0;
  int   seen_valid = 0;
  bit   have_cur = 0;
  exp_item_t cur;
  exp_item_t sb[$];

  falu_seq_if bus ();

  falu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [31:0] er, input logic [3:0] ef, input int lat,
                       input string nm);
    bit done = 0;
    bit rdy;
    exp_item_t it;
    @(negedge clk);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) done = 1;
      else @(negedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: got no accept expected accept within 200 cycles", nm);
    end else begin
      it.res = er; it.flags = ef; it.lat = lat; it.acc = cyc; it.nm = nm;
      sb.push_back(it);
      last_acc = cyc;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) idle = 1;
    end
    if (!idle) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_idle: got busy expected idle within 200 cycles", nm);
    end
  endtask

  // Monitor: pops one expectation per result and re-checks it every cycle it is held
  always @(negedge clk) begin
    if (!rst_n || !bus.out_valid) begin
      have_cur = 0;
    end else begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got result %h expected no output", bus.out_result);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          if (cur.lat != 0) check({cur.nm, "_latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end
      if (have_cur) begin
        check({cur.nm, "_result"}, 64'(bus.out_result), 64'(cur.res));
        check({cur.nm, "_flags"}, 64'(bus.out_flags), 64'(cur.flags));
        check({cur.nm, "_in_ready_low"}, 64'(bus.in_ready), 64'(0));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_result", 64'(bus.out_result), 64'(0));
    check("reset_flags", 64'(bus.out_flags), 64'(0));
    rst_n = 1'b1;

    // Arithmetic
    issue(32'h3F800000, 32'h40000000, ADD, 32'h40400000, 4'b0000, 3, "add_1_2");
    issue(32'h3FC00000, 32'h40000000, MUL, 32'h40400000, 4'b0000, 3, "mul_1p5_2");
    issue(32'hC0000000, 32'h40400000, MUL, 32'hC0C00000, 4'b0000, 3, "mul_neg");
    issue(32'h40400000, 32'h40400000, SUB, 32'h00000000, 4'b0000, 3, "sub_cancel");
    issue(32'h40A00000, 32'h3F800000, SUB, 32'h40800000, 4'b0000, 3, "sub_5_1");
    issue(32'h3F800000, 32'h33800000, ADD, 32'h3F800000, 4'b0000, 3, "add_tie_even");
    issue(32'h3F800000, 32'h40400000, DIV, 32'h3EAAAAAB, 4'b0000, 28, "div_1_3");
    issue(32'h40C00000, 32'h40000000, DIV, 32'h40400000, 4'b0000, 28, "div_6_2");

    // Specials, overflow, underflow
    issue(32'h3F800000, 32'h00000000, DIV, 32'h7F800000, 4'b0100, 2, "div_by_zero");
    issue(32'h7F800000, 32'h7F800000, SUB, 32'h7FC00000, 4'b1000, 2, "inf_minus_inf");
    issue(32'h7F800001, 32'h3F800000, ADD, 32'h7FC00000, 4'b1000, 2, "snan_add");
    issue(32'h7FC00000, 32'h3F800000, MUL, 32'h7FC00000, 4'b0000, 2, "qnan_mul");
    issue(32'h7F7FFFFF, 32'h40000000, MUL, 32'h7F800000, 4'b0010, 3, "mul_overflow");
    issue(32'h00800000, 32'h3F000000, MUL, 32'h00000000, 4'b0001, 3, "mul_underflow");
    wait_idle("arith");

    // Back-pressure: result held, new request accepted only after return to IDLE
    issue(32'h3F800000, 32'h40000000, ADD, 32'h40400000, 4'b0000, 3, "bp_hold");
    bus.out_ready = 1'b0;
    fork
      issue(32'h40A00000, 32'h3F800000, SUB, 32'h40800000, 4'b0000, 3, "bp_next");
      begin
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        rel_cyc = cyc;
        bus.out_ready = 1'b1;
      end
    join
    check("bp_accept_cycle", 64'(last_acc), 64'(rel_cyc + 2));
    wait_idle("bp");

    // Reset in the middle of a divide
    issue(32'h3F800000, 32'h40400000, DIV, 32'h3EAAAAAB, 4'b0000, 28, "div_abort");
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_result", 64'(bus.out_result), 64'(0));
    check("abort_flags", 64'(bus.out_flags), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    check("abort_no_out_valid", 64'(seen_valid), 64'(0));
    issue(32'h3F800000, 32'h40000000, ADD, 32'h40400000, 4'b0000, 3, "after_abort_add");
    wait_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
